counter_scheduler: RTL
======================

COUNTER_SCHEDULER -- requirements
Module: counter_scheduler

Interface
REQ-001 Parameter REQS, default 4: number of requesters; legal range 2..16.
REQ-002 Parameter WIDTH, default 8: interval counter width in bits.
REQ-003 Parameter IDXW, default log2(REQS): owner index width.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  REQS  per-requester level request; bit i held high until done[i] or voluntary drop.
REQ-007 len  input  REQS*WIDTH  interval length for requester i in bits [i*WIDTH +: WIDTH]; sampled only at grant.
REQ-008 tick  input  1  count-enable strobe; counter advances only in cycles where tick=1.
REQ-009 grant  output  REQS  one-hot ownership of the shared counter; all-zero when no owner.
REQ-010 done  output  REQS  one-cycle pulse to the owner when its interval expires.
REQ-011 abort  output  REQS  one-cycle pulse to the owner when its interval is cancelled by req drop.
REQ-012 owner  output  IDXW  index of current or most recent owner.
REQ-013 count  output  WIDTH  remaining ticks of the current interval.
REQ-014 busy  output  1  high in LOAD, RUN, DONE states.

Function
REQ-015 FSM states IDLE, LOAD, RUN, DONE; one state per cycle minimum.
REQ-016 IDLE: if any req bit is set, select winner by round-robin starting at (last_owner+1) mod REQS, wrapping; go LOAD; else stay IDLE.
REQ-017 LOAD: grant[winner]=1, owner=winner, count <= len[winner]; if len[winner]==0 go DONE, else go RUN.
REQ-018 RUN: when tick=1, count <= count-1; when count==1 and tick=1, count <= 0 and go DONE.
REQ-019 RUN: tick=0 holds count unchanged; no wrap below 0 under any condition.
REQ-020 RUN: if req[owner] falls, pulse abort[owner] on the next cycle, clear grant, update last_owner, go IDLE.
REQ-021 Simultaneous terminal tick and req[owner] drop in one cycle: completion wins; done pulses, abort does not.
REQ-022 DONE: done[owner]=1 for exactly one cycle, grant cleared in the same cycle, last_owner <= owner, go IDLE.
REQ-023 grant stays asserted, unchanged, from LOAD through the last RUN cycle; never more than one bit set.
REQ-024 Minimum interval latency: grant at cycle N (LOAD), done at N+1 for len=0, N+1+len tick cycles for len>0 with continuous tick.
REQ-025 A requester holding req after done re-competes in IDLE; round-robin prevents it from winning twice while another req is pending.
REQ-026 len changes after LOAD have no effect on the running interval.
REQ-027 done and abort are never asserted in the same cycle, and never for a non-owner.

Reset
REQ-028 reset_n low immediately forces state IDLE, grant=0, done=0, abort=0, count=0, owner=0, busy=0, last_owner=REQS-1, independent of clock.
REQ-029 Reset asserted mid-interval discards the interval with no done or abort pulse.
REQ-030 First arbitration after reset favours requester 0.

Verification
REQ-031 Reset, req=4'b0001, len0=3, tick=1 -> grant=0001 one cycle after request; count 3,2,1,0; done[0] pulse; busy low after.
REQ-032 req=4'b1111 held, all len=1, tick=1 -> grants issued in order 0,1,2,3,0; no requester granted twice consecutively.
REQ-033 req=4'b0100, len2=0 -> LOAD then DONE; done[2] pulse two cycles after request; count stays 0.
REQ-034 owner 1, len=5, tick toggling 1,0 -> count decrements only on tick cycles; done after 5 tick=1 cycles.
REQ-035 owner 3 in RUN with count=4, drop req[3] -> abort[3] pulse, no done[3], grant=0, next IDLE arbitration starts at requester 0.
REQ-036 reset_n low during RUN with count=2 -> outputs reach reset values before next clock edge; no done pulse after release.

Source files
------------

// File: rtl/counter_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : counter_scheduler
// Description : Round-robin arbiter that lends one shared down-counter to
//               REQS requesters. The winner's interval length is captured
//               at grant, then counted down on tick strobes. The owner gets
//               a done pulse on expiry or an abort pulse if it drops req.
// Revision    : 1.0  initial release
// ============================================================================
module counter_scheduler #(
  parameter int REQS  = 4,
  parameter int WIDTH = 8,
  parameter int IDXW  = $clog2(REQS)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [REQS-1:0]       req,
  input  logic [REQS*WIDTH-1:0] len,
  input  logic                  tick,
  output logic [REQS-1:0]       grant,
  output logic [REQS-1:0]       done,
  output logic [REQS-1:0]       abort,
  output logic [IDXW-1:0]       owner,
  output logic [WIDTH-1:0]      count,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [REQS-1:0]   grant_q, grant_d;
  logic [REQS-1:0]   done_q, done_d;
  logic [REQS-1:0]   abort_q, abort_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic [IDXW-1:0]   last_q, last_d;
  logic [WIDTH-1:0]  count_q, count_d;

  logic              w_found;
  logic [IDXW-1:0]   w_winner;
  logic [WIDTH-1:0]  w_owner_len;

  // Length slice of the current owner; only consumed in LOAD.
  assign w_owner_len = len[int'(owner_q)*WIDTH +: WIDTH];

  // Round-robin search starting just after the last owner, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_winner = last_q;
    for (int i = 1; i <= REQS; i++) begin
      if (!w_found && req[(int'(last_q) + i) % REQS]) begin
        w_found  = 1'b1;
        w_winner = IDXW'((int'(last_q) + i) % REQS);
      end
    end
  end

  // Next-state and next-output computation for the scheduler FSM.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    abort_d = '0;
    owner_d = owner_q;
    last_d  = last_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (w_found) begin
          state_d           = S_LOAD;
          owner_d           = w_winner;
          grant_d           = '0;
          grant_d[w_winner] = 1'b1;
        end
      end
      S_LOAD: begin
        count_d = w_owner_len;
        if (w_owner_len == '0) begin
          state_d          = S_DONE;
          done_d[owner_q]  = 1'b1;
          grant_d          = '0;
          last_d           = owner_q;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Terminal tick is checked first so completion beats a same-cycle drop.
        if (tick && count_q == WIDTH'(1)) begin
          state_d          = S_DONE;
          count_d          = '0;
          done_d[owner_q]  = 1'b1;
          grant_d          = '0;
          last_d           = owner_q;
        end else if (!req[owner_q]) begin
          state_d          = S_IDLE;
          abort_d[owner_q] = 1'b1;
          grant_d          = '0;
          last_d           = owner_q;
        end else if (tick && count_q != '0) begin
          count_d = count_q - WIDTH'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and registered outputs; reset discards any interval in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      done_q  <= '0;
      abort_q <= '0;
      owner_q <= '0;
      last_q  <= IDXW'(REQS - 1);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign abort = abort_q;
  assign owner = owner_q;
  assign count = count_q;
  assign busy  = (state_q != S_IDLE);

endmodule
`default_nettype wire
